// File: rtl/rsa_xcel_mont_modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer for Montgomery modular exponentiation.
// Issues one {n, opa, opb} request at a time to an external MontMulRem unit over val/rdy streams.
module rsa_xcel_mont_modexp_ctrl #(
   parameter int EXP_NBITS = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [95+EXP_NBITS:0]   istream_msg,
   input  logic                    istream_val,
   output logic                    istream_rdy,
   output logic [31:0]             ostream_msg,
   output logic                    ostream_val,
   input  logic                    ostream_rdy,
   output logic [95:0]             mulreq_msg,
   output logic                    mulreq_val,
   input  logic                    mulreq_rdy,
   input  logic [31:0]             mulresp_msg,
   input  logic                    mulresp_val,
   output logic                    mulresp_rdy,
   output logic                    busy
);

   typedef enum logic [2:0] {
      IDLE, CHECK, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, DONE
   } state_t;

   state_t               state_q, state_d;
   logic [31:0]          n_q, n_d;
   logic [31:0]          acc_q, acc_d;
   logic [31:0]          b_q, b_d;
   logic [EXP_NBITS-1:0] e_q, e_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         n_q     <= '0;
         acc_q   <= '0;
         b_q     <= '0;
         e_q     <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         e_q     <= e_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      acc_d       = acc_q;
      b_d         = b_q;
      e_d         = e_q;
      istream_rdy = 1'b0;
      ostream_val = 1'b0;
      ostream_msg = '0;
      mulreq_val  = 1'b0;
      mulreq_msg  = '0;
      mulresp_rdy = 1'b0;

      case (state_q)
         IDLE: begin
            istream_rdy = 1'b1;
            if (istream_val) begin
               n_d     = istream_msg[EXP_NBITS+95 -: 32];
               b_d     = istream_msg[EXP_NBITS+63 -: 32];
               acc_d   = istream_msg[EXP_NBITS+31 -: 32];
               e_d     = istream_msg[EXP_NBITS-1:0];
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (e_q == '0)     state_d = DONE;
            else if (e_q[0])   state_d = MUL_REQ;
            else               state_d = SQR_REQ;
         end
         MUL_REQ: begin
            mulreq_val = 1'b1;
            mulreq_msg = {n_q, acc_q, b_q};
            if (mulreq_rdy) state_d = MUL_WAIT;
         end
         MUL_WAIT: begin
            mulresp_rdy = 1'b1;
            if (mulresp_val) begin
               acc_d = mulresp_msg;
               // No higher exponent bits left: the trailing square would be wasted work.
               if ((e_q >> 1) == '0) begin
                  e_d     = '0;
                  state_d = DONE;
               end else begin
                  state_d = SQR_REQ;
               end
            end
         end
         SQR_REQ: begin
            mulreq_val = 1'b1;
            mulreq_msg = {n_q, b_q, b_q};
            if (mulreq_rdy) state_d = SQR_WAIT;
         end
         SQR_WAIT: begin
            mulresp_rdy = 1'b1;
            if (mulresp_val) begin
               b_d     = mulresp_msg;
               e_d     = e_q >> 1;
               state_d = CHECK;
            end
         end
         DONE: begin
            ostream_val = 1'b1;
            ostream_msg = acc_q;
            if (ostream_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

endmodule
